// File: rtl/fsm_run_serializer_pkg.sv
// Shared types and default sizes for the run serializer and its run-length tracker.
// Imported by the top-level serializer and the tracker sub-module.
package fsm_run_pkg;

  localparam int LEN_W_DEF  = 4;
  localparam int RUN_TH_DEF = 4;
  localparam int CNT_W_DEF  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/fsm_run_serializer_if.sv
// Command handshake and serial output bundle of the run serializer.
// master = command source / observer, slave = serializer.
interface fsm_run_serializer_if #(
  parameter int LEN_W = 4
);

  logic             in_valid;
  logic             in_bit;
  logic [LEN_W-1:0] in_len;
  logic             in_ready;
  logic             w;
  logic             w_valid;
  logic             z_exp;
  logic             busy;

  modport master (
    output in_valid,
    output in_bit,
    output in_len,
    input  in_ready,
    input  w,
    input  w_valid,
    input  z_exp,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  in_len,
    output in_ready,
    output w,
    output w_valid,
    output z_exp,
    output busy
  );

endinterface

// File: rtl/fsm_run_serializer_tracker.sv
// Cycle-exact model of the 4-in-a-row detector: counts consecutive equal samples of w
// (idle holds included) and flags when the run reaches the threshold.
module fsm_run_tracker
  import fsm_run_pkg::*;
#(
  parameter int RUN_TH = RUN_TH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic w,
  output logic z_exp
);

  logic [CNT_W-1:0] run_cnt_q;
  logic [CNT_W-1:0] run_cnt_d;
  logic             last_w_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(RUN_TH)) return CNT_W'(RUN_TH);
    return c + CNT_W'(1);
  endfunction

  // A zero count means no sample since reset, so the first sample always starts a new run.
  always_comb begin
    run_cnt_d = CNT_W'(1);
    if ((run_cnt_q != '0) && (w == last_w_q)) begin
      run_cnt_d = sat_inc(run_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt_q <= '0;
      last_w_q  <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      last_w_q  <= w;
    end
  end

  assign z_exp = (run_cnt_q == CNT_W'(RUN_TH));

endmodule

// File: rtl/fsm_run_serializer.sv
// Converts (bit, length) run commands into a one-bit-per-cycle stream w and
// predicts the downstream detector's z output on z_exp.
module fsm_run_serializer
  import fsm_run_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int RUN_TH = RUN_TH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  fsm_run_serializer_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] rem_d;
  logic             w_q;
  logic             w_d;
  logic             w_valid_q;
  logic             w_valid_d;
  logic             ready;
  logic             load;
  logic             last_bit;
  logic             z_exp_w;

  assign last_bit = (rem_q == LEN_W'(1));
  assign ready    = (state_q == IDLE) || ((state_q == SEND) && last_bit);
  // Zero-length commands are consumed by the handshake but never load a run.
  assign load     = bus.in_valid && ready && (bus.in_len != '0);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    w_d       = w_q;
    w_valid_d = w_valid_q;
    unique case (state_q)
      IDLE: begin
        w_valid_d = 1'b0;
        if (load) begin
          state_d   = SEND;
          rem_d     = bus.in_len;
          w_d       = bus.in_bit;
          w_valid_d = 1'b1;
        end
      end
      SEND: begin
        rem_d = rem_q - LEN_W'(1);
        if (last_bit) begin
          if (load) begin
            rem_d     = bus.in_len;
            w_d       = bus.in_bit;
            w_valid_d = 1'b1;
          end else begin
            state_d   = IDLE;
            w_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        w_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
    end
  end

  fsm_run_tracker #(
    .RUN_TH (RUN_TH),
    .CNT_W  (CNT_W)
  ) u_tracker (
    .clk   (clk),
    .reset (reset),
    .w     (w_q),
    .z_exp (z_exp_w)
  );

  assign bus.in_ready = ready;
  assign bus.w        = w_q;
  assign bus.w_valid  = w_valid_q;
  assign bus.z_exp    = z_exp_w;
  assign bus.busy     = (state_q == SEND);

endmodule

// File: tb/tb_fsm_run_serializer.sv
// Bench for fsm_run_serializer: directed run commands, a per-cycle reference model
// and hand-computed spot checks.
module tb_fsm_run_serializer;

  localparam int LEN_W  = 4;
  localparam int RUN_TH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fsm_run_serializer_if #(.LEN_W(LEN_W)) bus();

  fsm_run_serializer #(
    .LEN_W  (LEN_W),
    .RUN_TH (RUN_TH),
    .CNT_W  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bits still to send (incl. the one on w), the held w value,
  // and the last RUN_TH values of w the detector has sampled.
  int              m_rem   = 0;
  logic            m_w     = 1'b0;
  logic [RUN_TH-1:0] m_hist = '0;
  int              m_nsamp = 0;
  logic            exp_z;

  assign exp_z = (m_nsamp >= RUN_TH) && ((m_hist == '0) || (m_hist == '1));

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rem   <= 0;
      m_w     <= 1'b0;
      m_hist  <= '0;
      m_nsamp <= 0;
    end else begin
      m_hist <= {m_hist[RUN_TH-2:0], m_w};
      if (m_nsamp < RUN_TH) m_nsamp <= m_nsamp + 1;
      if (bus.in_valid && (m_rem <= 1) && (bus.in_len != '0)) begin
        m_rem <= int'(bus.in_len);
        m_w   <= bus.in_bit;
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
      end
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_w",        bus.w,        m_w);
      chk("cyc_w_valid",  bus.w_valid,  m_rem != 0);
      chk("cyc_in_ready", bus.in_ready, m_rem <= 1);
      chk("cyc_busy",     bus.busy,     m_rem != 0);
      chk("cyc_z_exp",    bus.z_exp,    exp_z);
    end
  end

  task automatic send(input logic b, input int len);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_len   = LEN_W'(len);
    while (!bus.in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("send_ready", bus.in_ready, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    int nv;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_len   = '0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_w",        bus.w,        1'b0);
    chk("rst_w_valid",  bus.w_valid,  1'b0);
    chk("rst_z_exp",    bus.z_exp,    1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_busy",     bus.busy,     1'b0);
    #2 reset = 1'b1;

    // 1: idle after reset, z_exp rises on the 4th edge
    repeat (3) @(negedge clk);
    chk("t1_z_edge3", bus.z_exp, 1'b0);
    @(negedge clk);
    chk("t1_z_edge4", bus.z_exp, 1'b1);
    chk("t1_w",       bus.w,     1'b0);
    chk("t1_w_valid", bus.w_valid, 1'b0);
    repeat (2) @(negedge clk);
    chk("t1_z_hold",  bus.z_exp, 1'b1);

    // 2: (1,4) from idle
    send(1'b1, 4);
    bus.in_valid = 1'b0;
    chk("t2_w_first",  bus.w,        1'b1);
    chk("t2_wv_first", bus.w_valid,  1'b1);
    chk("t2_z_first",  bus.z_exp,    1'b1);
    chk("t2_rdy_first", bus.in_ready, 1'b0);
    repeat (3) @(negedge clk);
    chk("t2_rdy_last", bus.in_ready, 1'b1);
    chk("t2_z_last",   bus.z_exp,    1'b0);
    chk("t2_w_last",   bus.w,        1'b1);
    @(negedge clk);
    chk("t2_wv_after", bus.w_valid,  1'b0);
    chk("t2_w_after",  bus.w,        1'b1);
    chk("t2_z_after",  bus.z_exp,    1'b1);
    repeat (2) @(negedge clk);
    chk("t2_z_hold",   bus.z_exp,    1'b1);

    // 3: back-to-back, zero runs merge
    send(1'b1, 3);
    send(1'b0, 2);
    send(1'b0, 2);
    bus.in_valid = 1'b0;
    chk("t3_w",      bus.w,       1'b0);
    chk("t3_wv",     bus.w_valid, 1'b1);
    @(negedge clk);
    chk("t3_z_3rd",  bus.z_exp,   1'b0);
    chk("t3_rdy",    bus.in_ready, 1'b1);
    @(negedge clk);
    chk("t3_z_4th",  bus.z_exp,   1'b1);
    chk("t3_wv_end", bus.w_valid, 1'b0);
    chk("t3_w_end",  bus.w,       1'b0);

    // 4: zero-length command in idle
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    bus.in_len   = '0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t4_w",    bus.w,        1'b0);
    chk("t4_wv",   bus.w_valid,  1'b0);
    chk("t4_rdy",  bus.in_ready, 1'b1);
    chk("t4_busy", bus.busy,     1'b0);

    // 5: maximum length run
    send(1'b0, 15);
    bus.in_valid = 1'b0;
    nz = 0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (!bus.in_ready) nz++;
      if (bus.w == 1'b0 && bus.w_valid) nv++;
      if (i < 14) @(negedge clk);
    end
    chk_int("t5_not_ready_cycles", nz, 14);
    chk_int("t5_zero_bits",        nv, 15);
    chk("t5_z_sat", bus.z_exp, 1'b1);
    @(negedge clk);
    chk("t5_wv_end",  bus.w_valid,  1'b0);
    chk("t5_rdy_end", bus.in_ready, 1'b1);

    // 6: reset in the middle of (1,8)
    send(1'b1, 8);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_w_bit5", bus.w, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t6_w",    bus.w,        1'b0);
    chk("t6_wv",   bus.w_valid,  1'b0);
    chk("t6_z",    bus.z_exp,    1'b0);
    chk("t6_rdy",  bus.in_ready, 1'b1);
    chk("t6_busy", bus.busy,     1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_z_edge3", bus.z_exp, 1'b0);
    @(negedge clk);
    chk("t6_z_edge4", bus.z_exp, 1'b1);
    chk("t6_wv_idle", bus.w_valid, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
